// File: rtl/frame_ingress_pkg.sv
// frame_ingress_pkg: FSM state encoding, default start-of-frame marker
// and a clog2 helper used to size the optional inter-byte timer.
package frame_ingress_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CHECK   = 2'd3
   } state_t;

   localparam logic [7:0] DEFAULT_SOF = 8'h7E;

   // Bits needed to count 0..v-1, never less than one.
   function automatic int clog2_min1(input int v);
      int n;
      n = 0;
      while ((1 << n) < v) n++;
      return (n < 1) ? 1 : n;
   endfunction

endpackage

// File: rtl/sat_counter8.sv
// sat_counter8: 8-bit event counter that sticks at 255.
// Ports: i_clk, i_rst_n (async, active-low), i_inc (count strobe), o_value.
module sat_counter8 (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_inc,
   output logic [7:0] o_value
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_value <= 8'd0;
      end else if (i_inc && (o_value != 8'hFF)) begin
         o_value <= o_value + 8'd1;
      end
   end

endmodule

// File: rtl/frame_ingress.sv
// frame_ingress: parses SOF/LEN/payload/XOR-checksum frames from a byte
// stream and writes payload into the circular buffer transactionally
// (push write index at frame start, pop it to discard a bad frame).
// Optional inter-byte timeout: define FRAME_INGRESS_TIMEOUT_EN.
// Ports: i_clk, i_rst_n (async, active-low), i_rx_data/i_rx_valid (bytes in),
//   i_data_size (buffer fill), o_data/o_write_en (payload write),
//   o_push_write_index/o_pop_write_index, o_frame_ok/o_frame_err strobes,
//   o_ok_count/o_err_count (saturating), o_busy (not IDLE).
module frame_ingress
   import frame_ingress_pkg::*;
#(
   parameter int         MAX_LEN        = 64,
   parameter int         BUFFER_SIZE    = 256,
   parameter logic [7:0] SOF_BYTE       = DEFAULT_SOF,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   input  logic [15:0] i_data_size,
   output logic [7:0]  o_data,
   output logic        o_write_en,
   output logic        o_push_write_index,
   output logic        o_pop_write_index,
   output logic        o_frame_ok,
   output logic        o_frame_err,
   output logic [7:0]  o_ok_count,
   output logic [7:0]  o_err_count,
   output logic        o_busy
);

   localparam logic [15:0] USABLE = 16'(BUFFER_SIZE - 1);

   if ((MAX_LEN < 1) || (MAX_LEN > 255) ||
       (BUFFER_SIZE < 2) || (TIMEOUT_CYCLES < 2)) begin : g_bad_cfg
      $error("frame_ingress: parameter out of range");
   end

   state_t      state;
   logic [7:0]  remaining;
   logic [7:0]  chk;
   logic [15:0] free_space;
   logic        len_bad;
   logic        ok_ev;
   logic        err_ev;
   logic        to_ev;
   logic        to_pop;

`ifdef FRAME_INGRESS_TIMEOUT_EN
   localparam int TW = clog2_min1(TIMEOUT_CYCLES);

   logic [TW-1:0] timer;

   // Counts idle cycles inside a frame; the TIMEOUT_CYCLES-th one fires.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         timer <= '0;
      end else if ((state == ST_IDLE) || i_rx_valid || to_ev) begin
         timer <= '0;
      end else begin
         timer <= timer + 1'b1;
      end
   end

   assign to_ev  = (state != ST_IDLE) && !i_rx_valid &&
                   (timer == TW'(TIMEOUT_CYCLES - 1));
   // Only PAYLOAD/CHECK follow a push, so only they need a rewind.
   assign to_pop = to_ev &&
                   ((state == ST_PAYLOAD) || (state == ST_CHECK));
`else
   assign to_ev  = 1'b0;
   assign to_pop = 1'b0;
`endif

   always_comb begin
      free_space = (i_data_size >= USABLE) ? 16'd0 : (USABLE - i_data_size);
      len_bad    = (i_rx_data == 8'd0) ||
                   (i_rx_data > 8'(MAX_LEN)) ||
                   ({8'd0, i_rx_data} > free_space);
      ok_ev      = 1'b0;
      err_ev     = to_ev;
      if (i_rx_valid) begin
         unique case (1'b1)
            (state == ST_LEN): begin
               err_ev = len_bad;
            end
            (state == ST_CHECK): begin
               ok_ev  = (i_rx_data == chk);
               err_ev = (i_rx_data != chk);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state              <= ST_IDLE;
         remaining          <= 8'd0;
         chk                <= 8'd0;
         o_data             <= 8'd0;
         o_write_en         <= 1'b0;
         o_push_write_index <= 1'b0;
         o_pop_write_index  <= 1'b0;
         o_frame_ok         <= 1'b0;
         o_frame_err        <= 1'b0;
         o_busy             <= 1'b0;
      end else begin
         o_write_en         <= 1'b0;
         o_push_write_index <= 1'b0;
         o_pop_write_index  <= to_pop;
         o_frame_ok         <= ok_ev;
         o_frame_err        <= err_ev;
         if (to_ev) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
         end else if (i_rx_valid) begin
            unique case (state)
               ST_IDLE: begin
                  if (i_rx_data == SOF_BYTE) begin
                     state  <= ST_LEN;
                     o_busy <= 1'b1;
                  end
               end
               ST_LEN: begin
                  if (len_bad) begin
                     state  <= ST_IDLE;
                     o_busy <= 1'b0;
                  end else begin
                     o_push_write_index <= 1'b1;
                     remaining          <= i_rx_data;
                     chk                <= i_rx_data;
                     state              <= ST_PAYLOAD;
                  end
               end
               ST_PAYLOAD: begin
                  o_write_en <= 1'b1;
                  o_data     <= i_rx_data;
                  chk        <= chk ^ i_rx_data;
                  remaining  <= remaining - 8'd1;
                  if (remaining == 8'd1) state <= ST_CHECK;
               end
               ST_CHECK: begin
                  o_pop_write_index <= !ok_ev;
                  state             <= ST_IDLE;
                  o_busy            <= 1'b0;
               end
               default: begin
                  state  <= ST_IDLE;
                  o_busy <= 1'b0;
               end
            endcase
         end
      end
   end

   sat_counter8 u_ok_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (ok_ev),
      .o_value (o_ok_count)
   );

   sat_counter8 u_err_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (err_ev),
      .o_value (o_err_count)
   );

endmodule

// File: tb/tb_frame_ingress.sv
// tb_frame_ingress: table vectors, hand sequences and random frames
// checked against a frame-level model of frame_ingress.
module tb_frame_ingress;

   localparam int         MAX_LEN = 64;
   localparam int         USABLE  = 255;
   localparam logic [7:0] SOF     = 8'h7E;
   localparam int         TO_CYC  = 1024;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic [7:0]  rx_data  = 8'h00;
   logic        rx_valid = 1'b0;
   logic [15:0] dsz      = 16'd0;
   logic [7:0]  o_data;
   logic        wr_en;
   logic        push;
   logic        pop;
   logic        f_ok;
   logic        f_err;
   logic [7:0]  ok_cnt;
   logic [7:0]  err_cnt;
   logic        busy;

   always #5 clk = ~clk;

   frame_ingress dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_rx_data          (rx_data),
      .i_rx_valid         (rx_valid),
      .i_data_size        (dsz),
      .o_data             (o_data),
      .o_write_en         (wr_en),
      .o_push_write_index (push),
      .o_pop_write_index  (pop),
      .o_frame_ok         (f_ok),
      .o_frame_err        (f_err),
      .o_ok_count         (ok_cnt),
      .o_err_count        (err_cnt),
      .o_busy             (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int mon_push = 0, mon_pop = 0, mon_ok = 0, mon_err = 0, mon_excl = 0;
   int b_push, b_pop, b_ok, b_err;
   int exp_ok = 0, exp_err = 0;
   logic [7:0] wq[$];
   logic [7:0] exp_wq[$];

   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_en) wq.push_back(o_data);
         if (push)  mon_push++;
         if (pop)   mon_pop++;
         if (f_ok)  mon_ok++;
         if (f_err) mon_err++;
         if ((int'(wr_en) + int'(push) + int'(pop)) > 1) mon_excl++;
      end
   end

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic snap();
      b_push = mon_push;
      b_pop  = mon_pop;
      b_ok   = mon_ok;
      b_err  = mon_err;
      wq.delete();
      exp_wq.delete();
   endtask

   task automatic check_frame(input string tag, input int e_push,
                              input int e_pop, input int e_ok,
                              input int e_err);
      check({tag, ".push"}, 32'(mon_push - b_push), 32'(e_push));
      check({tag, ".pop"},  32'(mon_pop - b_pop),   32'(e_pop));
      check({tag, ".ok"},   32'(mon_ok - b_ok),     32'(e_ok));
      check({tag, ".err"},  32'(mon_err - b_err),   32'(e_err));
      check({tag, ".nwr"},  32'(wq.size()),         32'(exp_wq.size()));
      for (int i = 0; i < exp_wq.size() && i < wq.size(); i++)
         check({tag, ".data"}, 32'(wq[i]), 32'(exp_wq[i]));
      check({tag, ".ok_count"},  32'(ok_cnt),  32'(exp_ok));
      check({tag, ".err_count"}, 32'(err_cnt), 32'(exp_err));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         rx_valid = 1'b0;
      end
   endtask

   task automatic send(input logic [7:0] b, input bit gaps);
      if (gaps) idle($urandom_range(0, 2));
      @(posedge clk); #1;
      rx_data  = b;
      rx_valid = 1'b1;
   endtask

   task automatic drive_frame(input logic [7:0] len, input logic [7:0] pay[$],
                              input logic [7:0] cbyte, input bit body,
                              input bit gaps);
      send(SOF, gaps);
      send(len, gaps);
      if (body) begin
         foreach (pay[i]) send(pay[i], gaps);
         send(cbyte, gaps);
      end
   endtask

   typedef struct {
      string       name;
      logic [7:0]  len;
      logic [7:0]  seed;
      logic [7:0]  cxor;
      logic [15:0] size;
      int          e_push, e_pop, e_wr, e_ok, e_err;
   } vec_t;

   function automatic vec_t mk(input string n, input logic [7:0] l,
                               input logic [7:0] s, input logic [7:0] x,
                               input logic [15:0] d, input int p,
                               input int q, input int w, input int o,
                               input int e);
      vec_t v;
      v.name = n; v.len = l; v.seed = s; v.cxor = x; v.size = d;
      v.e_push = p; v.e_pop = q; v.e_wr = w; v.e_ok = o; v.e_err = e;
      return v;
   endfunction

   vec_t tbl[14];

   initial begin
      logic [7:0] pay[$];
      logic [7:0] x;
      logic [7:0] len;
      logic [7:0] cb;
      logic [15:0] size;
      int kind, freesp;
      bit acc, good;

      tbl[0]  = mk("t_len1",   8'd1,   8'h7E, 8'h00, 16'd0,   1, 0, 1,  1, 0);
      tbl[1]  = mk("t_len0",   8'd0,   8'h00, 8'h00, 16'd0,   0, 0, 0,  0, 1);
      tbl[2]  = mk("t_len65",  8'd65,  8'h00, 8'h00, 16'd0,   0, 0, 0,  0, 1);
      tbl[3]  = mk("t_len255", 8'd255, 8'h00, 8'h00, 16'd0,   0, 0, 0,  0, 1);
      tbl[4]  = mk("t_len64",  8'd64,  8'h40, 8'h00, 16'd0,   1, 0, 64, 1, 0);
      tbl[5]  = mk("t_sp252",  8'd4,   8'h10, 8'h00, 16'd252, 0, 0, 0,  0, 1);
      tbl[6]  = mk("t_sp251",  8'd4,   8'h10, 8'h00, 16'd251, 1, 0, 4,  1, 0);
      tbl[7]  = mk("t_sp254",  8'd1,   8'h01, 8'h00, 16'd254, 1, 0, 1,  1, 0);
      tbl[8]  = mk("t_sp255",  8'd1,   8'h01, 8'h00, 16'd255, 0, 0, 0,  0, 1);
      tbl[9]  = mk("t_sp300",  8'd1,   8'h01, 8'h00, 16'd300, 0, 0, 0,  0, 1);
      tbl[10] = mk("t_bad64",  8'd64,  8'hC0, 8'h80, 16'd0,   1, 1, 64, 0, 1);
      tbl[11] = mk("t_chk7e",  8'd2,   8'h7E, 8'h01, 16'd10,  1, 1, 2,  0, 1);
      tbl[12] = mk("t_sp191",  8'd64,  8'h00, 8'h00, 16'd191, 1, 0, 64, 1, 0);
      tbl[13] = mk("t_sp192",  8'd64,  8'h00, 8'h00, 16'd192, 0, 0, 0,  0, 1);

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.data",   32'(o_data),  32'd0);
      check("rst.wr",     32'(wr_en),   32'd0);
      check("rst.push",   32'(push),    32'd0);
      check("rst.pop",    32'(pop),     32'd0);
      check("rst.ok",     32'(f_ok),    32'd0);
      check("rst.err",    32'(f_err),   32'd0);
      check("rst.okcnt",  32'(ok_cnt),  32'd0);
      check("rst.errcnt", 32'(err_cnt), 32'd0);
      check("rst.busy",   32'(busy),    32'd0);
      rst_n = 1'b1;
      idle(2);

      // Good frame with per-cycle timing.
      snap();
      send(SOF, 0);
      send(8'h03, 0);
      @(negedge clk);
      check("good.busy_after_sof", 32'(busy), 32'd1);
      send(8'h11, 0);
      @(negedge clk);
      check("good.push_after_len", 32'(push), 32'd1);
      check("good.no_wr_at_push",  32'(wr_en), 32'd0);
      send(8'h22, 0);
      @(negedge clk);
      check("good.wr1",      32'(wr_en), 32'd1);
      check("good.wr1_data", 32'(o_data), 32'h11);
      check("good.push_low", 32'(push), 32'd0);
      send(8'h33, 0);
      send(8'h03, 0);
      idle(1);
      @(negedge clk);
      check("good.frame_ok", 32'(f_ok), 32'd1);
      check("good.busy_end", 32'(busy), 32'd0);
      check("good.okcnt_now", 32'(ok_cnt), 32'd1);
      idle(2);
      exp_wq = '{8'h11, 8'h22, 8'h33};
      exp_ok = 1;
      check_frame("good", 1, 0, 1, 0);

      // Bad checksum.
      snap();
      pay = '{8'hAA, 8'h55};
      drive_frame(8'h02, pay, 8'h00, 1'b1, 1'b0);
      idle(3);
      exp_wq = '{8'hAA, 8'h55};
      exp_err = 1;
      check_frame("badchk", 1, 1, 0, 1);

      // Table vectors.
      for (int t = 0; t < 14; t++) begin
         snap();
         dsz = tbl[t].size;
         pay.delete();
         x = tbl[t].len;
         if (tbl[t].e_push != 0) begin
            for (int i = 0; i < int'(tbl[t].len); i++) begin
               pay.push_back(tbl[t].seed + 8'(i));
               x = x ^ (tbl[t].seed + 8'(i));
            end
         end
         drive_frame(tbl[t].len, pay, x ^ tbl[t].cxor,
                     tbl[t].e_push != 0, 1'b0);
         idle(3);
         for (int i = 0; i < tbl[t].e_wr; i++)
            exp_wq.push_back(tbl[t].seed + 8'(i));
         exp_ok  = sat(exp_ok + tbl[t].e_ok);
         exp_err = sat(exp_err + tbl[t].e_err);
         check_frame(tbl[t].name, tbl[t].e_push, tbl[t].e_pop,
                     tbl[t].e_ok, tbl[t].e_err);
      end

      // Random frames against the frame-level model.
      for (int f = 0; f < 120; f++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0)      len = 8'd0;
         else if (kind == 1) len = 8'($urandom_range(MAX_LEN + 1, 255));
         else                len = 8'($urandom_range(1, MAX_LEN));
         size = (kind == 2) ? 16'($urandom_range(200, 300))
                            : 16'($urandom_range(0, 180));
         pay.delete();
         x = len;
         if (int'(len) <= MAX_LEN) begin
            for (int i = 0; i < int'(len); i++) begin
               pay.push_back(8'($urandom_range(0, 255)));
               x = x ^ pay[i];
            end
         end
         cb = (kind == 3) ? (x ^ 8'($urandom_range(1, 255))) : x;
         freesp = (int'(size) >= USABLE) ? 0 : USABLE - int'(size);
         acc  = (len != 8'd0) && (int'(len) <= MAX_LEN) &&
                (int'(len) <= freesp);
         good = acc && (cb == x);
         snap();
         dsz = size;
         drive_frame(len, pay, cb, acc, 1'b1);
         idle(3);
         if (acc) exp_wq = pay;
         exp_ok  = sat(exp_ok + int'(good));
         exp_err = sat(exp_err + int'(!good));
         check_frame("rand", int'(acc), int'(acc && !good),
                     int'(good), int'(!good));
      end

      // Back-to-back good frames until the ok counter saturates.
      snap();
      dsz = 16'd0;
      for (int f = 0; f < 300; f++) begin
         len = 8'($urandom_range(1, 4));
         pay.delete();
         x = len;
         for (int i = 0; i < int'(len); i++) begin
            pay.push_back(8'($urandom_range(0, 255)));
            x = x ^ pay[i];
         end
         foreach (pay[i]) exp_wq.push_back(pay[i]);
         drive_frame(len, pay, x, 1'b1, 1'b0);
      end
      idle(3);
      exp_ok = sat(exp_ok + 300);
      check_frame("stream", 300, 0, 300, 0);
      check("stream.sat", 32'(ok_cnt), 32'd255);

      // Long stall inside a frame that stays below any timeout.
      snap();
      send(SOF, 0);
      send(8'h03, 0);
      send(8'hA1, 0);
      send(8'hB2, 0);
      idle(50);
      send(8'hC3, 0);
      send(8'h03 ^ 8'hA1 ^ 8'hB2 ^ 8'hC3, 0);
      idle(3);
      exp_wq = '{8'hA1, 8'hB2, 8'hC3};
      check_frame("stall", 1, 0, 1, 0);

`ifdef FRAME_INGRESS_TIMEOUT_EN
      snap();
      send(SOF, 0);
      send(8'h05, 0);
      send(8'h11, 0);
      send(8'h22, 0);
      idle(TO_CYC + 5);
      exp_wq = '{8'h11, 8'h22};
      exp_err = sat(exp_err + 1);
      check_frame("to_pay", 1, 1, 0, 1);

      snap();
      send(SOF, 0);
      idle(TO_CYC + 5);
      exp_err = sat(exp_err + 1);
      check_frame("to_len", 0, 0, 0, 1);
`endif

      // Asynchronous reset in the middle of a payload.
      snap();
      send(SOF, 0);
      send(8'h03, 0);
      send(8'hAA, 0);
      send(8'hBB, 0);
      @(negedge clk);
      #1;
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      #1;
      check("mid.data",   32'(o_data),  32'd0);
      check("mid.wr",     32'(wr_en),   32'd0);
      check("mid.pop",    32'(pop),     32'd0);
      check("mid.err",    32'(f_err),   32'd0);
      check("mid.okcnt",  32'(ok_cnt),  32'd0);
      check("mid.errcnt", 32'(err_cnt), 32'd0);
      check("mid.busy",   32'(busy),    32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_ok  = 0;
      exp_err = 0;
      exp_wq  = '{8'hAA};
      check_frame("mid", 1, 0, 0, 0);

      snap();
      pay = '{8'h05};
      drive_frame(8'h01, pay, 8'h04, 1'b1, 1'b0);
      idle(3);
      exp_wq = '{8'h05};
      exp_ok = 1;
      check_frame("post_rst", 1, 0, 1, 0);

      check("exclusive", 32'(mon_excl), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
